ag32gbd_block_buffer: RTL and testbench
=======================================

AG32GBD_BLOCK_BUFFER -- requirements
Module: ag32gbd_block_buffer

Interface
REQ-001 sys_clock  in  1  system clock; all logic clocks on its rising edge.
REQ-002 sys_resetn  in  1  reset, asynchronous, active-low; one clock, no other clock domains.
REQ-003 NewRunReset  in  1  synchronous frame restart, active-high.
REQ-004 Pixel_Valid  in  1  one-cycle strobe; one quantised pixel present.
REQ-005 Pixel_Value  in  2  2-bit pixel, raster order, 128 px/row.
REQ-006 BlockBufferDataReady  out  1  a full 8-row block is offered to the downstream RAM writer.
REQ-007 Gbd_Writing_Ram  in  1  downstream writer busy; high while it consumes the offered block.
REQ-008 RequestReadBuffer  in  1  downstream byte-read request.
REQ-009 ReadBufferOffset  in  10  byte offset {row[2:0], byte[4:0]}; bits [9:8] nominally 0.
REQ-010 BufferDataReady  out  1  BufferReadResult valid for the last request.
REQ-011 BufferReadResult  out  8  packed byte; leftmost pixel in [7:6].
REQ-012 Block_Index  out  4  index of the block currently offered (0..15).
REQ-013 Frame_Done  out  1  all 16 blocks of the frame handed off.
REQ-014 Overflow  out  1  sticky; pixels were dropped.

Function
REQ-015 Storage: two 256x8 banks (ping-pong); one is the fill bank, the other the read bank.
REQ-016 Packing: pixel n of a block goes to fill-bank byte n[9:2], bits [7-2*n[1:0] -: 2]; the byte is written on the 4th pixel, so the 1024th pixel completes byte 0xFF.
REQ-017 Fill FSM states: F_FILL (accept pixels) and F_FULL (block complete, waiting for swap); F_FILL -> F_FULL after pixel 1023.
REQ-018 Read-bank FSM states: R_FREE, R_OFFERED, R_BUSY.
REQ-019 Swap: when the fill FSM is in F_FULL and the read bank is in R_FREE, in one cycle: exchange banks, reset the pixel counter to 0, fill FSM -> F_FILL, read FSM -> R_OFFERED, Block_Index <= fill block count.
REQ-020 BlockBufferDataReady = (read FSM == R_OFFERED); it holds high until Gbd_Writing_Ram is seen high; R_OFFERED -> R_BUSY.
REQ-021 R_BUSY -> R_FREE on the first cycle Gbd_Writing_Ram is low.
REQ-022 F_FULL entered and R_FREE in the same cycle: swap occurs on the next cycle; no pixel is lost if Pixel_Valid is low in that cycle.
REQ-023 Pixel_Valid high while in F_FULL: the pixel is dropped and Overflow is set.
REQ-024 Read port, request side: on a rising edge of RequestReadBuffer, latch ReadBufferOffset and drive BufferDataReady to 0 the next cycle.
REQ-025 Read port, result side: 2 cycles after the edge, BufferReadResult = read-bank byte and BufferDataReady = 1; both hold until the next rising edge.
REQ-026 Read port: holding the request high does not re-trigger; ReadBufferOffset[9:8] != 0 returns 0x00.
REQ-027 Fill and read ports operate concurrently with no stalls.
REQ-028 Frame: the fill block counter (4 bits) increments at each swap.
REQ-029 Frame_Done is set when block 15 leaves R_BUSY; all further pixels are ignored (no Overflow).
REQ-030 NewRunReset (synchronous, highest priority): clears FSMs, counters, flags and outputs to reset values; memory contents are unchanged.

Reset
REQ-031 When sys_resetn is low: fill FSM = F_FILL, read FSM = R_FREE, pixel counter = 0, block counter = 0, bank select = 0.
REQ-032 When sys_resetn is low, all outputs = 0 (BufferDataReady 0, BufferReadResult 0x00).
REQ-033 Reset asserted mid-block abandons the block; no partial block is ever offered.

Structure
REQ-034 ag32gbd_pkg holds BYTES_PER_BLOCK=256, PIXELS_PER_BLOCK=1024, BLOCKS_PER_FRAME=16, READ_LATENCY=2, and the FSM state encodings.
REQ-035 Sub-module ag32gbd_dpram_256x8: 1 write port and 1 registered read port, instantiated twice.

Verification
REQ-036 Single block: 1024 pixels of pattern 0,1,2,3 -> BlockBufferDataReady rises; read of offset 0x000 -> 0x1B after 2 cycles with BufferDataReady=1; Block_Index=0.
REQ-037 Handshake: hold Gbd_Writing_Ram low 50 cycles -> ready stays high; raise busy -> ready drops next cycle; drop busy -> R_FREE.
REQ-038 Overflow: keep busy high while a 2nd block fills plus 4 extra pixels -> Overflow=1 and the 3rd block's byte 0 reflects only pixels after the swap.
REQ-039 Frame: 16 blocks with consumer emulation -> Frame_Done after 16th busy fall; a 17th block of pixels is ignored and Overflow stays 0.
REQ-040 Boundaries: offset 0x0FF returns the last byte; offset 0x100 -> 0x00.
REQ-041 Mid-operation resets: NewRunReset at pixel 500 -> counters 0, ready 0; sys_resetn low during R_BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/ag32gbd_block_buffer_pkg.sv
// Shared constants, FSM encodings and the byte-packing helper for the 8-row block buffer.
// Pure definitions; no latency or backpressure of its own.
package ag32gbd_pkg;

    localparam int BYTES_PER_BLOCK  = 256;
    localparam int PIXELS_PER_BLOCK = 1024;
    localparam int BLOCKS_PER_FRAME = 16;
    localparam int READ_LATENCY     = 2;

    typedef enum logic {
        F_FILL = 1'b0,
        F_FULL = 1'b1
    } fill_state_t;

    typedef enum logic [1:0] {
        R_FREE    = 2'd0,
        R_OFFERED = 2'd1,
        R_BUSY    = 2'd2
    } read_state_t;

    // Three earlier pixels sit in acc[5:0], oldest in the top bits, so it lands leftmost.
    function automatic logic [7:0] pack_byte(input logic [5:0] acc, input logic [1:0] px);
        return {acc, px};
    endfunction

endpackage

// File: rtl/ag32gbd_block_buffer_if.sv
// Pixel-in, block-handoff and byte-read signals of the block buffer.
// slave = buffer side, master = pixel source plus downstream RAM writer.
interface ag32gbd_block_buffer_if;
    logic       Pixel_Valid;
    logic [1:0] Pixel_Value;
    logic       BlockBufferDataReady;
    logic       Gbd_Writing_Ram;
    logic       RequestReadBuffer;
    logic [9:0] ReadBufferOffset;
    logic       BufferDataReady;
    logic [7:0] BufferReadResult;
    logic [3:0] Block_Index;
    logic       Frame_Done;
    logic       Overflow;

    modport slave (
        input  Pixel_Valid, Pixel_Value, Gbd_Writing_Ram, RequestReadBuffer, ReadBufferOffset,
        output BlockBufferDataReady, BufferDataReady, BufferReadResult, Block_Index,
               Frame_Done, Overflow
    );

    modport master (
        output Pixel_Valid, Pixel_Value, Gbd_Writing_Ram, RequestReadBuffer, ReadBufferOffset,
        input  BlockBufferDataReady, BufferDataReady, BufferReadResult, Block_Index,
               Frame_Done, Overflow
    );
endinterface

// File: rtl/ag32gbd_block_buffer_dpram.sv
// 256x8 RAM with one write port and one registered read port.
// Read data appears one clock after the address; no backpressure.
module ag32gbd_dpram_256x8
    import ag32gbd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [7:0] i_wdat,
    input  logic [7:0] i_raddr,
    output logic [7:0] o_rdat
);

    logic [7:0] r_mem [BYTES_PER_BLOCK];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
        o_rdat <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ag32gbd_block_buffer.sv
// Ping-pong 8-row block buffer: packs 2-bit pixels into bytes, offers full blocks downstream.
// Byte reads return 2 clocks after a request edge; pixels arriving while both banks are held are dropped.
module ag32gbd_block_buffer
    import ag32gbd_pkg::*;
(
    input  logic                          sys_clock,
    input  logic                          sys_resetn,
    input  logic                          NewRunReset,
    ag32gbd_block_buffer_if.slave         bb
);

    localparam logic [9:0] LAST_PIXEL = 10'(PIXELS_PER_BLOCK - 1);
    localparam logic [3:0] LAST_BLOCK = 4'(BLOCKS_PER_FRAME - 1);

    fill_state_t r_fill_state;
    read_state_t r_read_state;
    logic [9:0]  r_pix_cnt;
    logic [5:0]  r_acc;
    logic        r_bank_sel;
    logic [3:0]  r_fill_blk;
    logic [3:0]  r_blk_idx;
    logic        r_bbdr;
    logic        r_frame_done;
    logic        r_overflow;

    logic                    r_req_d;
    logic [7:0]              r_rd_off;
    logic                    r_rd_oob;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic                    r_rd_sel;
    logic                    r_bdr;
    logic [7:0]              r_result;

    logic       w_pix_ok;
    logic       w_pix_drop;
    logic       w_swap;
    logic       w_byte_done;
    logic       w_we0;
    logic       w_we1;
    logic [7:0] w_wdat;
    logic [7:0] w_rdat0;
    logic [7:0] w_rdat1;
    logic       w_req_rise;

    assign w_pix_ok    = bb.Pixel_Valid && (r_fill_state == F_FILL) && !r_frame_done;
    assign w_pix_drop  = bb.Pixel_Valid && (r_fill_state == F_FULL) && !r_frame_done;
    assign w_swap      = (r_fill_state == F_FULL) && (r_read_state == R_FREE) && !r_frame_done;
    assign w_byte_done = w_pix_ok && (r_pix_cnt[1:0] == 2'b11) && !NewRunReset;
    assign w_we0       = w_byte_done && !r_bank_sel;
    assign w_we1       = w_byte_done &&  r_bank_sel;
    assign w_wdat      = pack_byte(r_acc, bb.Pixel_Value);
    assign w_req_rise  = bb.RequestReadBuffer && !r_req_d;

    ag32gbd_dpram_256x8 u_bank0 (
        .i_clk   (sys_clock),
        .i_we    (w_we0),
        .i_waddr (r_pix_cnt[9:2]),
        .i_wdat  (w_wdat),
        .i_raddr (r_rd_off),
        .o_rdat  (w_rdat0)
    );

    ag32gbd_dpram_256x8 u_bank1 (
        .i_clk   (sys_clock),
        .i_we    (w_we1),
        .i_waddr (r_pix_cnt[9:2]),
        .i_wdat  (w_wdat),
        .i_raddr (r_rd_off),
        .o_rdat  (w_rdat1)
    );

    // Fill and read-bank FSMs share one block so the swap updates both atomically.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_fill_state <= F_FILL;
            r_read_state <= R_FREE;
            r_pix_cnt    <= '0;
            r_acc        <= '0;
            r_bank_sel   <= 1'b0;
            r_fill_blk   <= '0;
            r_blk_idx    <= '0;
            r_bbdr       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (NewRunReset) begin
            r_fill_state <= F_FILL;
            r_read_state <= R_FREE;
            r_pix_cnt    <= '0;
            r_acc        <= '0;
            r_bank_sel   <= 1'b0;
            r_fill_blk   <= '0;
            r_blk_idx    <= '0;
            r_bbdr       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_pix_ok) begin
                r_acc     <= {r_acc[3:0], bb.Pixel_Value};
                r_pix_cnt <= r_pix_cnt + 10'd1;
                if (r_pix_cnt == LAST_PIXEL) begin
                    r_fill_state <= F_FULL;
                end
            end
            if (w_pix_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_read_state)
                R_OFFERED: begin
                    if (bb.Gbd_Writing_Ram) begin
                        r_read_state <= R_BUSY;
                        r_bbdr       <= 1'b0;
                    end
                end
                R_BUSY: begin
                    if (!bb.Gbd_Writing_Ram) begin
                        r_read_state <= R_FREE;
                        if (r_blk_idx == LAST_BLOCK) begin
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_swap) begin
                r_bank_sel   <= ~r_bank_sel;
                r_pix_cnt    <= '0;
                r_fill_state <= F_FILL;
                r_read_state <= R_OFFERED;
                r_bbdr       <= 1'b1;
                r_blk_idx    <= r_fill_blk;
                r_fill_blk   <= r_fill_blk + 4'd1;
            end
        end
    end

    // The bank choice is sampled alongside the RAM read so a swap mid-read cannot mix banks.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_req_d   <= 1'b0;
            r_rd_off  <= '0;
            r_rd_oob  <= 1'b0;
            r_rd_pipe <= '0;
            r_rd_sel  <= 1'b0;
            r_bdr     <= 1'b0;
            r_result  <= '0;
        end else if (NewRunReset) begin
            r_req_d   <= 1'b0;
            r_rd_off  <= '0;
            r_rd_oob  <= 1'b0;
            r_rd_pipe <= '0;
            r_rd_sel  <= 1'b0;
            r_bdr     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_req_d   <= bb.RequestReadBuffer;
            r_rd_pipe <= {r_rd_pipe[READ_LATENCY-2:0], w_req_rise};
            if (w_req_rise) begin
                r_rd_off <= bb.ReadBufferOffset[7:0];
                r_rd_oob <= |bb.ReadBufferOffset[9:8];
                r_bdr    <= 1'b0;
            end
            if (r_rd_pipe[0]) begin
                r_rd_sel <= ~r_bank_sel;
            end
            if (r_rd_pipe[READ_LATENCY-1] && !w_req_rise) begin
                r_bdr    <= 1'b1;
                r_result <= r_rd_oob ? 8'h00 : (r_rd_sel ? w_rdat1 : w_rdat0);
            end
        end
    end

    assign bb.BlockBufferDataReady = r_bbdr;
    assign bb.BufferDataReady      = r_bdr;
    assign bb.BufferReadResult     = r_result;
    assign bb.Block_Index          = r_blk_idx;
    assign bb.Frame_Done           = r_frame_done;
    assign bb.Overflow             = r_overflow;

endmodule

// File: tb/tb_ag32gbd_block_buffer.sv
// Directed-plus-random bench for the block buffer against an event-level model of blocks and handoffs.
module tb_ag32gbd_block_buffer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic nrr   = 1'b0;

    always #5 clk = ~clk;

    ag32gbd_block_buffer_if bb();

    ag32gbd_block_buffer dut (
        .sys_clock   (clk),
        .sys_resetn  (rst_n),
        .NewRunReset (nrr),
        .bb          (bb)
    );

    // Model: pixel lists per bank, consumer status (0 free, 1 offered, 2 busy), counters and flags.
    int m_fill [1024];
    int m_read [1024];
    int m_fill_n;
    int m_rstate;
    int m_blk;
    int m_idx;
    int m_ovf;
    int m_done;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_fill_n = 0;
        m_rstate = 0;
        m_blk    = 0;
        m_idx    = 0;
        m_ovf    = 0;
        m_done   = 0;
    endtask

    task automatic m_try_swap();
        if (m_fill_n == 1024 && m_rstate == 0 && m_done == 0) begin
            for (int i = 0; i < 1024; i++) m_read[i] = m_fill[i];
            m_fill_n = 0;
            m_rstate = 1;
            m_idx    = m_blk;
            m_blk    = (m_blk + 1) % 16;
        end
    endtask

    function automatic int exp_byte(input int off);
        if (off >= 256) return 0;
        return m_read[4*off] * 64 + m_read[4*off+1] * 16 + m_read[4*off+2] * 4 + m_read[4*off+3];
    endfunction

    task automatic send_pix(input int v);
        bb.Pixel_Valid = 1'b1;
        bb.Pixel_Value = 2'(v);
        step();
        bb.Pixel_Valid = 1'b0;
        if (m_done == 0) begin
            if (m_fill_n < 1024) begin
                m_fill[m_fill_n] = v;
                m_fill_n++;
            end else begin
                m_ovf = 1;
            end
        end
        if ($urandom_range(0, 3) == 0) step();
    endtask

    // pat < 0 gives random pixels, otherwise the repeating 0,1,2,3 ramp.
    task automatic fill(input int n, input int pat);
        for (int i = 0; i < n; i++) send_pix(pat < 0 ? int'($urandom_range(0, 3)) : (i % 4));
        step();
        step();
        m_try_swap();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_ready"}, 32'(bb.BlockBufferDataReady), 32'(m_rstate == 1));
        check({tag, "_idx"},   32'(bb.Block_Index),          32'(m_idx));
        check({tag, "_ovf"},   32'(bb.Overflow),             32'(m_ovf));
        check({tag, "_done"},  32'(bb.Frame_Done),           32'(m_done));
    endtask

    task automatic do_read(input string tag, input int off, input int hold, output logic [7:0] res);
        bb.RequestReadBuffer = 1'b1;
        bb.ReadBufferOffset  = 10'(off);
        step();
        check({tag, "_pend"}, 32'(bb.BufferDataReady), 32'd0);
        step();
        step();
        check({tag, "_rdy"},  32'(bb.BufferDataReady),  32'd1);
        check({tag, "_byte"}, 32'(bb.BufferReadResult), 32'(exp_byte(off)));
        res = bb.BufferReadResult;
        for (int i = 0; i < hold; i++) step();
        if (hold > 0) begin
            check({tag, "_hold_rdy"},  32'(bb.BufferDataReady),  32'd1);
            check({tag, "_hold_byte"}, 32'(bb.BufferReadResult), 32'(exp_byte(off)));
        end
        bb.RequestReadBuffer = 1'b0;
        step();
    endtask

    task automatic consume_begin(input string tag);
        bb.Gbd_Writing_Ram = 1'b1;
        step();
        m_rstate = 2;
        check({tag, "_busy_ready"}, 32'(bb.BlockBufferDataReady), 32'd0);
    endtask

    task automatic consume_end();
        bb.Gbd_Writing_Ram = 1'b0;
        step();
        m_rstate = 0;
        if (m_idx == 15) m_done = 1;
        step();
        m_try_swap();
    endtask

    initial begin
        logic [7:0] rd;
        int         lows;

        bb.Pixel_Valid       = 1'b0;
        bb.Pixel_Value       = 2'd0;
        bb.Gbd_Writing_Ram   = 1'b0;
        bb.RequestReadBuffer = 1'b0;
        bb.ReadBufferOffset  = 10'd0;
        m_reset();

        step();
        step();
        check("reset_outputs",
              32'({bb.BlockBufferDataReady, bb.BufferDataReady, bb.BufferReadResult,
                   bb.Block_Index, bb.Frame_Done, bb.Overflow}), 32'd0);
        rst_n = 1'b1;
        step();

        // Single block of the 0,1,2,3 ramp.
        fill(1024, 0);
        check_status("blk0");
        do_read("blk0_rd0", 0, 0, rd);
        check("blk0_rd0_const", 32'(rd), 32'h1B);

        // Ready holds while the writer is idle, then drops one cycle after busy.
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bb.BlockBufferDataReady !== 1'b1) lows++;
        end
        check("hs_hold_lows", 32'(lows), 32'd0);
        consume_begin("hs");

        // Second block fills while the first is still busy, then four pixels overflow.
        fill(1028, -1);
        check_status("ovf");
        consume_end();
        check_status("blk1");
        do_read("blk1_rd0",    0,     3, rd);
        do_read("blk1_rdlast", 'h0FF, 0, rd);
        do_read("blk1_rdoob",  'h100, 0, rd);
        check("blk1_rdoob_const", 32'(rd), 32'd0);
        do_read("blk1_rdrand", int'($urandom_range(0, 255)), 1, rd);
        consume_begin("blk1");
        consume_end();

        // Third block starts clean after the swap.
        fill(1024, -1);
        check_status("blk2");
        do_read("blk2_rd0", 0, 0, rd);
        consume_begin("blk2");
        consume_end();

        // Restart mid-block.
        fill(500, -1);
        nrr = 1'b1;
        step();
        nrr = 1'b0;
        m_reset();
        check_status("nrr");

        // Full frame with consumer emulation.
        for (int b = 0; b < 16; b++) begin
            fill(1024, -1);
            check_status($sformatf("frm%0d", b));
            do_read($sformatf("frm%0d_rd", b), int'($urandom_range(0, 255)), 0, rd);
            consume_begin($sformatf("frm%0d", b));
            consume_end();
        end
        check_status("frame_end");
        fill(1024, -1);
        check_status("frame_extra");

        // Async reset while the writer is busy.
        nrr = 1'b1;
        step();
        nrr = 1'b0;
        m_reset();
        fill(1024, -1);
        check_status("arst_blk");
        do_read("arst_rd", 5, 0, rd);
        consume_begin("arst");
        rst_n = 1'b0;
        #1;
        check("arst_outputs",
              32'({bb.BlockBufferDataReady, bb.BufferDataReady, bb.BufferReadResult,
                   bb.Block_Index, bb.Frame_Done, bb.Overflow}), 32'd0);
        bb.Gbd_Writing_Ram = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
